avalon_bidir_pio: RTL and testbench

- Parametrised Avalon-MM bidirectional parallel I/O slave.
- Generalises the single-bit SDA/SCL pin controllers to WIDTH pins, each with its own direction bit.
- Adds an input synchroniser, atomic set/clear output writes, edge capture and a maskable level interrupt.
- Sits between the SOPC interconnect and board pins (I2C, GPIO headers).

---
 rtl/avalon_pio_pkg.sv | 26 ++
 rtl/pio_edge_sync.sv | 73 +++++++
 rtl/avalon_bidir_pio.sv | 106 ++++++++++
 tb/tb_avalon_bidir_pio.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/avalon_pio_pkg.sv
// Shared definitions for the Avalon-MM bidirectional PIO slave.
//   REG_W          : Avalon data bus width
//   ADDR_*         : register map offsets
//   EDGE_*         : edge-capture mode encodings
//   arm_state_t    : states of the post-reset edge-detect arming FSM
package avalon_pio_pkg;

   localparam int unsigned REG_W = 32;

   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_DIR     = 3'd1;
   localparam logic [2:0] ADDR_IRQMASK = 3'd2;
   localparam logic [2:0] ADDR_EDGECAP = 3'd3;
   localparam logic [2:0] ADDR_OUTSET  = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

   localparam int unsigned EDGE_RISING  = 0;
   localparam int unsigned EDGE_FALLING = 1;
   localparam int unsigned EDGE_ANY     = 2;

   typedef enum logic {
      ARMING,
      ARMED
   } arm_state_t;

endpackage

// File: rtl/pio_edge_sync.sv
// Input synchroniser, prev-sample flop and edge detector for the PIO pins.
//   clk, reset_n : clock, asynchronous active-low reset
//   pin_in       : raw pin values (asynchronous to clk)
//   sync_in      : pin values after SYNC_STAGES flops
//   edge_pulse   : one-cycle pulse per bit on an edge of sync_in (EDGE_TYPE)
// Edge detection stays disabled until the chain and prev-sample flop hold
// real pin data, so the zeroed chain cannot produce a false edge.
module pio_edge_sync
   import avalon_pio_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned EDGE_TYPE   = EDGE_RISING,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] pin_in,
   output logic [WIDTH-1:0] sync_in,
   output logic [WIDTH-1:0] edge_pulse
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                  prev_q;
   logic [WIDTH-1:0]                  raw_edge;
   arm_state_t                        state_q, state_d;
   logic [2:0]                        cnt_q, cnt_d;
   logic                              armed;

   assign sync_in = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q  <= '0;
         prev_q  <= '0;
         state_q <= ARMING;
         cnt_q   <= '0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], pin_in};
         prev_q  <= sync_in;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Arms on the (SYNC_STAGES+1)-th clock after reset release, the first
   // point at which both sync_in and prev_q carry sampled pin data.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      armed   = 1'b0;
      case (state_q)
         ARMING: begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'(SYNC_STAGES))
               state_d = ARMED;
         end
         ARMED: armed = 1'b1;
         default: state_d = ARMING;
      endcase
   end

   always_comb begin
      raw_edge = '0;
      case (EDGE_TYPE)
         EDGE_RISING:  raw_edge = sync_in & ~prev_q;
         EDGE_FALLING: raw_edge = ~sync_in & prev_q;
         default:      raw_edge = sync_in ^ prev_q;
      endcase
   end

   assign edge_pulse = armed ? raw_edge : '0;

endmodule

// File: rtl/avalon_bidir_pio.sv
// Avalon-MM bidirectional parallel I/O slave, WIDTH pins with per-pin
// direction, atomic set/clear writes, edge capture and masked level irq.
//   clk, reset_n : clock, asynchronous active-low reset
//   address      : register select (DATA, DIR, IRQMASK, EDGECAP, OUTSET, OUTCLR)
//   chipselect   : slave select
//   write_n      : active-low write strobe
//   writedata    : write data, bits above WIDTH ignored
//   readdata     : registered read data, one cycle latency, no read strobe
//   bidir_port   : pins
//   irq          : level interrupt, |(edge_cap & irq_mask), registered
// Build option AVALON_BIDIR_PIO_OPEN_DRAIN_EN: pins are only ever pulled low
// (driven 0 when dir=1 and data_out=0, otherwise Z); default is push-pull.
module avalon_bidir_pio
   import avalon_pio_pkg::*;
#(
   parameter int unsigned      WIDTH       = 8,
   parameter int unsigned      EDGE_TYPE   = EDGE_RISING,
   parameter logic [WIDTH-1:0] DOUT_RESET  = '1,
   parameter int unsigned      SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [REG_W-1:0]      writedata,
   output logic [REG_W-1:0]      readdata,
   inout  wire logic [WIDTH-1:0] bidir_port,
   output logic                  irq
);

   logic [WIDTH-1:0] data_out;
   logic [WIDTH-1:0] data_dir;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] sync_in;
   logic [WIDTH-1:0] edge_pulse;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] w1c;
   logic [REG_W-1:0] rd_mux;
   logic             wr;
   logic             writedata_unused;

   assign wd               = writedata[WIDTH-1:0];
   assign writedata_unused = ^writedata;
   assign wr               = chipselect & ~write_n;
   assign w1c              = (wr && address == ADDR_EDGECAP) ? wd : '0;

   pio_edge_sync #(
      .WIDTH       (WIDTH),
      .EDGE_TYPE   (EDGE_TYPE),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge_sync (
      .clk        (clk),
      .reset_n    (reset_n),
      .pin_in     (bidir_port),
      .sync_in    (sync_in),
      .edge_pulse (edge_pulse)
   );

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA:    rd_mux = REG_W'(sync_in);
         ADDR_DIR:     rd_mux = REG_W'(data_dir);
         ADDR_IRQMASK: rd_mux = REG_W'(irq_mask);
         ADDR_EDGECAP: rd_mux = REG_W'(edge_cap);
         default:      rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out <= DOUT_RESET;
         data_dir <= '0;
         irq_mask <= '0;
         edge_cap <= '0;
         readdata <= '0;
         irq      <= 1'b0;
      end else begin
         if (wr) begin
            case (address)
               ADDR_DATA:    data_out <= wd;
               ADDR_DIR:     data_dir <= wd;
               ADDR_IRQMASK: irq_mask <= wd;
               ADDR_OUTSET:  data_out <= data_out | wd;
               ADDR_OUTCLR:  data_out <= data_out & ~wd;
               default:      ;
            endcase
         end
         // Set dominates clear when an edge lands on the W1C cycle.
         edge_cap <= (edge_cap & ~w1c) | edge_pulse;
         irq      <= |(edge_cap & irq_mask);
         readdata <= rd_mux;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
`ifdef AVALON_BIDIR_PIO_OPEN_DRAIN_EN
      assign bidir_port[i] = (data_dir[i] & ~data_out[i]) ? 1'b0 : 1'bz;
`else
      assign bidir_port[i] = data_dir[i] ? data_out[i] : 1'bz;
`endif
   end

endmodule

// File: tb/tb_avalon_bidir_pio.sv
// Directed self-checking bench for avalon_bidir_pio (WIDTH=8, rising edge,
// SYNC_STAGES=2). Pins carry pull-ups; an undriven pin reads 1.
module tb_avalon_bidir_pio;
   import avalon_pio_pkg::*;

   localparam int unsigned W = 8;
   localparam int unsigned S = 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [2:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic          irq;
   wire  [W-1:0]  pins;
   logic [W-1:0]  ext_oe;
   logic [W-1:0]  ext_val;

   int unsigned   n_checks = 0;
   int unsigned   n_fail   = 0;

   for (genvar g = 0; g < W; g++) begin : g_ext
      pullup (pins[g]);
      assign pins[g] = ext_oe[g] ? ext_val[g] : 1'bz;
   end

   always #5 clk = ~clk;

   avalon_bidir_pio #(
      .WIDTH       (W),
      .EDGE_TYPE   (EDGE_RISING),
      .DOUT_RESET  (8'hFF),
      .SYNC_STAGES (S)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .bidir_port (pins),
      .irq        (irq)
   );

   typedef struct {
      bit          do_wr;
      logic [2:0]  waddr;
      logic [31:0] wdata;
      logic [2:0]  raddr;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      address = a;
      @(negedge clk);
      d = readdata;
   endtask

   logic [31:0] rd;
   bit          got;

   initial begin
      vecs[0]  = '{1'b1, ADDR_DIR,     32'hFFFF_FF0F, ADDR_DIR,     32'h0F, "dir_upper_bits"};
      vecs[1]  = '{1'b1, ADDR_DATA,    32'hA5,        ADDR_DATA,    32'hF5, "data_a5_dir0f"};
      vecs[2]  = '{1'b0, ADDR_DATA,    32'h0,         ADDR_EDGECAP, 32'h00, "no_rising_yet"};
      vecs[3]  = '{1'b1, ADDR_OUTSET,  32'h30,        ADDR_OUTSET,  32'h00, "outset_reads0"};
      vecs[4]  = '{1'b1, ADDR_OUTCLR,  32'h01,        ADDR_OUTCLR,  32'h00, "outclr_reads0"};
      vecs[5]  = '{1'b1, ADDR_DIR,     32'hFF,        ADDR_DATA,    32'hB4, "data_out_b4"};
      vecs[6]  = '{1'b1, ADDR_DIR,     32'h0F,        ADDR_DATA,    32'hF4, "release_upper"};
      vecs[7]  = '{1'b0, ADDR_DATA,    32'h0,         ADDR_EDGECAP, 32'h40, "own_edge_pin6"};
      vecs[8]  = '{1'b1, ADDR_EDGECAP, 32'h40,        ADDR_EDGECAP, 32'h00, "w1c_pin6"};
      vecs[9]  = '{1'b1, ADDR_IRQMASK, 32'h04,        ADDR_IRQMASK, 32'h04, "irqmask_rw"};
      vecs[10] = '{1'b1, 3'd6,         32'hFF,        3'd6,         32'h00, "reserved6"};
      vecs[11] = '{1'b0, ADDR_DATA,    32'h0,         3'd7,         32'h00, "reserved7"};

      reset_n    = 1'b0;
      address    = ADDR_DATA;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      ext_oe     = '0;
      ext_val    = '0;

      #12;
      check("reset_readdata", readdata, 32'h0);
      check("reset_irq", {31'b0, irq}, 32'h0);
      check("reset_pins_z", {24'b0, pins}, 32'hFF);

      @(negedge clk);
      reset_n = 1'b1;
      repeat (S + 2) @(negedge clk);
      check("data_after_reset", readdata, 32'hFF);
      bus_read(ADDR_EDGECAP, rd);
      check("no_false_edge", rd, 32'h0);
      check("irq_after_reset", {31'b0, irq}, 32'h0);

      for (int i = 0; i < 12; i++) begin
         if (vecs[i].do_wr)
            bus_write(vecs[i].waddr, vecs[i].wdata);
         repeat (4) @(negedge clk);
         bus_read(vecs[i].raddr, rd);
         check(vecs[i].name, rd, vecs[i].exp);
      end

      // Release pins, hold pin2 low externally, clear the edges from release.
      bus_write(ADDR_DIR, 32'h00);
      ext_oe[2]  = 1'b1;
      ext_val[2] = 1'b0;
      repeat (6) @(negedge clk);
      bus_write(ADDR_EDGECAP, 32'hFF);
      bus_read(ADDR_EDGECAP, rd);
      check("edgecap_cleared", rd, 32'h0);
      check("irq_low_before_edge", {31'b0, irq}, 32'h0);

      // External rising edge on pin2 with IRQMASK=0x04.
      ext_val[2] = 1'b1;
      got = 1'b0;
      for (int c = 1; c <= S + 3; c++) begin
         @(negedge clk);
         if (irq) begin
            got = 1'b1;
            break;
         end
      end
      check("irq_on_pin2_rise", {31'b0, got}, 32'h1);
      bus_read(ADDR_EDGECAP, rd);
      check("edgecap_pin2", rd, 32'h04);

      bus_write(ADDR_EDGECAP, 32'h04);
      check("irq_held_on_w1c_edge", {31'b0, irq}, 32'h1);
      @(negedge clk);
      check("irq_cleared_after_w1c", {31'b0, irq}, 32'h0);

      // Falling edge must not capture; then rising edge coincident with W1C.
      ext_val[2] = 1'b0;
      repeat (5) @(negedge clk);
      bus_read(ADDR_EDGECAP, rd);
      check("falling_ignored", rd, 32'h0);
      ext_val[2] = 1'b1;
      repeat (S - 1) @(negedge clk);
      bus_write(ADDR_EDGECAP, 32'h04);
      bus_read(ADDR_EDGECAP, rd);
      check("set_wins_over_w1c", rd, 32'h04);
      check("irq_after_set_wins", {31'b0, irq}, 32'h1);

      // Drive pin0 low, then assert reset mid-drive.
      ext_oe = '0;
      bus_write(ADDR_DIR, 32'h01);
`ifdef AVALON_BIDIR_PIO_OPEN_DRAIN_EN
      bus_write(ADDR_DATA, 32'h01);
      check("od_high_is_z", {31'b0, pins[0]}, 32'h1);
`endif
      bus_write(ADDR_DATA, 32'h00);
      check("pin0_driven_low", {31'b0, pins[0]}, 32'h0);
      #2;
      reset_n = 1'b0;
      #1;
      check("reset_pin0_z", {31'b0, pins[0]}, 32'h1);
      check("reset_irq_async", {31'b0, irq}, 32'h0);
      check("reset_readdata_async", readdata, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
